// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit adder/subtractor, one S-bit slice per stage.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   operation handshake (in_ready = pipeline advances)
//   A, B, Cin, Sub      operands; Sub=1 computes A-B (Cin ignored)
//   out_valid/out_ready result handshake; outputs held while stalled
//   Result              sum/difference modulo 2^WIDTH
//   Cout, Over          carry out of MSB (1 = no borrow on subtract), signed overflow
//   Zero, Neg           Result == 0, Result[WIDTH-1]
//
// Stage k register set holds the operands (upper slices still needed), the
// result with slices 0..k filled in, the slice carry, and the running zero
// term. The last stage's registers are the outputs, so latency is STAGES.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Over,
    output logic             Zero,
    output logic             Neg
);
    localparam int S = WIDTH / STAGES;

    logic adv;

    // stage registers
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, r_q;
    logic [STAGES-1:0]            c_q, z_q, vld_pipe;
    logic                         over_q;

    // per-stage sources (previous register, or the input port for stage 0)
    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, r_in, r_nx;
    logic [STAGES-1:0]            c_in, z_in, v_in, c_nx, z_nx;
    logic                         over_nx;

    // Whole-pipe stall: nothing moves while a result is waiting.
    assign adv      = !vld_pipe[STAGES-1] || out_ready;
    assign in_ready = adv;

    // B is inverted once at capture so later stages only ever add.
    assign a_in[0] = A;
    assign b_in[0] = Sub ? ~B : B;
    assign c_in[0] = Sub | Cin;
    assign r_in[0] = '0;
    assign z_in[0] = 1'b1;
    assign v_in[0] = in_valid;

    genvar k;
    generate
        for (k = 1; k < STAGES; k++) begin : g_link
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign r_in[k] = r_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign z_in[k] = z_q[k-1];
            assign v_in[k] = vld_pipe[k-1];
        end

        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [S-1:0]     as, bs;
            logic [S:0]       sum;
            logic [WIDTH-1:0] rn;

            assign as  = a_in[k][k*S +: S];
            assign bs  = b_in[k][k*S +: S];
            assign sum = {1'b0, as} + {1'b0, bs} + {{S{1'b0}}, c_in[k]};

            always_comb begin
                rn             = r_in[k];
                rn[k*S +: S]   = sum[S-1:0];
            end

            assign r_nx[k] = rn;
            assign c_nx[k] = sum[S];
            assign z_nx[k] = z_in[k] & (sum[S-1:0] == '0);

            if (k == STAGES - 1) begin : g_last
                // carry into the MSB recovered from the MSB sum bit
                assign over_nx = (sum[S-1] ^ as[S-1] ^ bs[S-1]) ^ sum[S];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            z_q      <= '0;
            vld_pipe <= '0;
            over_q   <= 1'b0;
        end else if (adv) begin
            a_q      <= a_in;
            b_q      <= b_in;
            r_q      <= r_nx;
            c_q      <= c_nx;
            z_q      <= z_nx;
            vld_pipe <= v_in;
            over_q   <= over_nx;
        end
    end

    // Operands in the last stage have been fully consumed.
    logic unused_ops;
    assign unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

    assign out_valid = vld_pipe[STAGES-1];
    assign Result    = r_q[STAGES-1];
    assign Cout      = c_q[STAGES-1];
    assign Over      = over_q;
    assign Zero      = z_q[STAGES-1];
    assign Neg       = r_q[STAGES-1][WIDTH-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and model-checked bench for pipe_adder at three configurations:
// 32/4 (sel 0), 8/1 (sel 1), 64/8 (sel 2). Expected results sit in a queue
// and are compared every cycle a result is visible.
module tb_pipe_adder;
    logic        clk, rst_n;
    logic [63:0] a, b;
    logic        cin, sub, ordy;
    logic [2:0]  iv, rdy, ov, co, ovf, zr, ng;
    logic [31:0] res32;
    logic [7:0]  res8;
    logic [63:0] res64;

    pipe_adder #(.WIDTH(32), .STAGES(4)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
        .A(a[31:0]), .B(b[31:0]), .Cin(cin), .Sub(sub),
        .out_valid(ov[0]), .out_ready(ordy), .Result(res32),
        .Cout(co[0]), .Over(ovf[0]), .Zero(zr[0]), .Neg(ng[0]));

    pipe_adder #(.WIDTH(8), .STAGES(1)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
        .A(a[7:0]), .B(b[7:0]), .Cin(cin), .Sub(sub),
        .out_valid(ov[1]), .out_ready(ordy), .Result(res8),
        .Cout(co[1]), .Over(ovf[1]), .Zero(zr[1]), .Neg(ng[1]));

    pipe_adder #(.WIDTH(64), .STAGES(8)) u_d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
        .A(a), .B(b), .Cin(cin), .Sub(sub),
        .out_valid(ov[2]), .out_ready(ordy), .Result(res64),
        .Cout(co[2]), .Over(ovf[2]), .Zero(zr[2]), .Neg(ng[2]));

    typedef struct {
        logic [63:0] r;
        logic        c, o, z, n;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          sel;
    int          errs, checks, cyc, vcnt;
    int          lat_of [3] = '{4, 1, 8};
    int          wid_of [3] = '{32, 8, 64};

    logic        m_v, m_rdy, m_c, m_o, m_z, m_n;
    logic [63:0] m_r;

    always_comb begin
        m_r = res64;
        case (sel)
            0:       m_r = {32'd0, res32};
            1:       m_r = {56'd0, res8};
            default: m_r = res64;
        endcase
        m_v   = ov[sel];
        m_rdy = rdy[sel];
        m_c   = co[sel];
        m_o   = ovf[sel];
        m_z   = zr[sel];
        m_n   = ng[sel];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s (dut %0d): got %h expected %h", tag, sel, got, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [63:0] ta, input logic [63:0] tb_,
                                   input logic tc, input logic ts);
        exp_t        e;
        logic [63:0] mask, aa, be;
        logic [64:0] full;
        mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        aa    = ta & mask;
        be    = (ts ? ~tb_ : tb_) & mask;
        full  = {1'b0, aa} + {1'b0, be} + 65'(ts | tc);
        e.r   = full[63:0] & mask;
        e.c   = full[w];
        e.o   = (aa[w-1] == be[w-1]) && (e.r[w-1] != aa[w-1]);
        e.z   = (e.r == 64'd0);
        e.n   = e.r[w-1];
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // One clock: drive for the coming edge, then inspect the visible result.
    task automatic step(input logic v, input logic [63:0] ta, input logic [63:0] tb_,
                        input logic tc, input logic ts, input logic tor,
                        input exp_t e, output logic acc);
        exp_t ee;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts; ordy = tor;
        iv = '0; iv[sel] = v;
        cyc++;
        #1;
        if (m_v) begin
            vcnt++;
            chk("valid_with_pending", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                chk("result", m_r, q[0].r);
                chk("flags_czon", 64'({m_c, m_o, m_z, m_n}),
                    64'({q[0].c, q[0].o, q[0].z, q[0].n}));
                if (q[0].lat) chk("latency", 64'(cyc - q[0].acc), 64'(lat_of[sel]));
                if (ordy) void'(q.pop_front());
            end
        end
        acc = v && m_rdy;
        if (acc) begin
            ee     = e;
            ee.acc = cyc;
            q.push_back(ee);
        end
    endtask

    task automatic drain();
        exp_t e;
        logic acc;
        int   n;
        e = '{default: 0};
        n = 0;
        while (q.size() > 0 && n < 40) begin
            step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, e, acc);
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    task automatic dir(input logic [63:0] ta, input logic [63:0] tb_, input logic tc,
                       input logic ts, input logic [63:0] er, input logic ec,
                       input logic eo, input logic ez, input logic en);
        exp_t e;
        logic acc;
        int   n;
        e = '{r: er, c: ec, o: eo, z: ez, n: en, acc: 0, lat: 1'b1};
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            step(1'b1, ta, tb_, tc, ts, 1'b1, e, acc);
            n++;
        end
        chk("dir_accept", 64'(acc), 64'd1);
        drain();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic burst(input int n);
        exp_t        e;
        logic        acc;
        logic [63:0] ta, tb_;
        logic        tc, ts;
        vcnt = 0;
        for (int i = 0; i < n; i++) begin
            ta = rnd64(); tb_ = rnd64();
            tc = 1'($urandom_range(1)); ts = 1'($urandom_range(1));
            e = model(wid_of[sel], ta, tb_, tc, ts);
            e.lat = 1'b1;
            step(1'b1, ta, tb_, tc, ts, 1'b1, e, acc);
            chk("burst_ready", 64'(acc), 64'd1);
        end
        drain();
        chk("burst_count", 64'(vcnt), 64'(n));
    endtask

    initial begin : main
        exp_t        e;
        logic        acc;
        logic [63:0] ta, tb_;
        int          n;
        errs = 0; checks = 0; cyc = 0; vcnt = 0; sel = 0;
        rst_n = 1'b0; iv = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; ordy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_valid", 64'(m_v), 64'd0);
            chk("rst_ready", 64'(m_rdy), 64'd1);
            chk("rst_result", m_r, 64'd0);
            chk("rst_flags", 64'({m_c, m_o, m_z, m_n}), 64'd0);
        end

        // 32-bit, 4 stages
        sel = 0;
        dir(64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0,        1, 0, 1, 0);
        dir(64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000, 0, 1, 0, 1);
        dir(64'h0000FFFF, 64'h1, 1'b1, 1'b0, 64'h00010001, 0, 0, 0, 0);
        dir(64'h5,        64'h7, 1'b1, 1'b1, 64'hFFFFFFFE, 0, 0, 0, 1);
        dir(64'h80000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFF, 1, 1, 0, 0);
        dir(64'h1234,  64'h1234, 1'b0, 1'b1, 64'h0,        1, 0, 1, 0);
        burst(16);

        // backpressure: fill, stall 5 cycles while a new op waits, release
        for (int i = 0; i < 4; i++) begin
            ta = rnd64(); tb_ = rnd64();
            e = model(32, ta, tb_, 1'b0, 1'(i & 1));
            step(1'b1, ta, tb_, 1'b0, 1'(i & 1), 1'b1, e, acc);
        end
        ta = rnd64(); tb_ = rnd64();
        e = model(32, ta, tb_, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ta, tb_, 1'b1, 1'b0, 1'b0, e, acc);
            chk("stall_ready", 64'(m_rdy), 64'd0);
            chk("stall_valid", 64'(m_v), 64'd1);
            chk("stall_noaccept", 64'(acc), 64'd0);
        end
        acc = 1'b0;
        n = 0;
        while (!acc && n < 10) begin
            step(1'b1, ta, tb_, 1'b1, 1'b0, 1'b1, e, acc);
            n++;
        end
        chk("stall_release_accept", 64'(acc), 64'd1);
        drain();

        // reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            ta = rnd64(); tb_ = rnd64() | 64'h1;
            e = model(32, ta, tb_, 1'b1, 1'b0);
            step(1'b1, ta, tb_, 1'b1, 1'b0, 1'b1, e, acc);
        end
        @(negedge clk);
        rst_n = 1'b0; iv = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("flush_valid", 64'(m_v), 64'd0);
        chk("flush_result", m_r, 64'd0);
        chk("flush_flags", 64'({m_c, m_o, m_z, m_n}), 64'd0);
        chk("flush_ready", 64'(m_rdy), 64'd1);
        q.delete();
        vcnt = 0;
        e = '{default: 0};
        repeat (8) step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, e, acc);
        chk("flush_no_output", 64'(vcnt), 64'd0);

        // 8-bit, single stage
        sel = 1;
        dir(64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1, 0, 1, 0);
        dir(64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 0, 1, 0, 1);
        dir(64'h0F, 64'h01, 1'b1, 1'b0, 64'h11, 0, 0, 0, 0);
        dir(64'h05, 64'h07, 1'b1, 1'b1, 64'hFE, 0, 0, 0, 1);
        dir(64'h80, 64'h01, 1'b0, 1'b1, 64'h7F, 1, 1, 0, 0);
        burst(8);

        // 64-bit, 8 stages
        sel = 2;
        dir(64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1, 0, 1, 0);
        dir(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000_00000000, 0, 1, 0, 1);
        dir(64'h00000000_FFFFFFFF, 64'h1, 1'b1, 1'b0, 64'h00000001_00000001, 0, 0, 0, 0);
        dir(64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFE, 0, 0, 0, 1);
        dir(64'h80000000_00000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 1, 1, 0, 0);
        burst(8);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
